// File: rtl/inst_fetch_unit_pkg.sv
// ISA constants and fetch-path types shared by the
// instruction fetch unit and its queue.
package inst_fetch_unit_pkg;

    localparam logic [5:0] OPC_NOP   = 6'b000000;
    localparam logic [5:0] OPC_ADD   = 6'b000001;
    localparam logic [5:0] OPC_SUB   = 6'b000010;
    localparam logic [5:0] OPC_AND   = 6'b000011;
    localparam logic [5:0] OPC_OR    = 6'b000100;
    localparam logic [5:0] OPC_LOAD  = 6'b000101;
    localparam logic [5:0] OPC_STORE = 6'b000110;
    localparam logic [5:0] OPC_ADDF  = 6'b000111;
    localparam logic [5:0] OPC_MULF  = 6'b001000;
    localparam logic [5:0] OPC_JUMP  = 6'b010101;
    localparam logic [5:0] OPC_BRA   = 6'b010110;

    localparam int OPC_HI   = 31;
    localparam int OPC_LO   = 26;
    localparam int RS1_HI   = 25;
    localparam int RS1_LO   = 21;
    localparam int RS2_HI   = 20;
    localparam int RS2_LO   = 16;
    localparam int RD_HI    = 15;
    localparam int RD_LO    = 11;
    localparam int IMM16_HI = 15;
    localparam int IMM16_LO = 0;
    localparam int JIMM_HI  = 25;
    localparam int JIMM_LO  = 0;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fq_entry_t;

    function automatic logic is_jump(input logic [31:0] w);
        return w[OPC_HI:OPC_LO] == OPC_JUMP;
    endfunction

    function automatic logic [31:0] jump_target(input logic [31:0] w);
        return {6'b0, w[JIMM_HI:JIMM_LO]};
    endfunction

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Fetch unit bus: instruction-memory port, execute
// redirect and the valid/ready hand-off to decode.
interface inst_fetch_unit_if;

    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        halted;

    modport master (
        output imem_addr,
        input  imem_data,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_inst,
        output out_pc,
        output halted
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_inst,
        input  out_pc,
        input  halted
    );

endinterface

// File: rtl/inst_fetch_unit_queue.sv
// Synchronous FIFO of {inst, pc} entries with flush;
// head reads as zero whenever the queue is empty.
module inst_fetch_unit_queue
    import inst_fetch_unit_pkg::*;
#(
    parameter int QDEPTH = 4
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    flush_i,
    input  logic                    push_i,
    input  fq_entry_t               push_data_i,
    input  logic                    pop_i,
    output logic [$clog2(QDEPTH):0] count_o,
    output fq_entry_t               head_o
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    fq_entry_t         mem_q [QDEPTH];
    logic [PW-1:0]     wr_q, wr_d;
    logic [PW-1:0]     rd_q, rd_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              do_push;
    logic              do_pop;

    assign do_push = push_i && (cnt_q != CW'(QDEPTH));
    assign do_pop  = pop_i && (cnt_q != '0);

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + 1'b1;
            if (do_pop)  rd_d = rd_q + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage is not reset; only entries below count are ever visible.
    always_ff @(posedge clock) begin
        if (reset_n && !flush_i && do_push) begin
            mem_q[wr_q] <= push_data_i;
        end
    end

    assign count_o = cnt_q;
    assign head_o  = (cnt_q == '0) ? '0 : mem_q[rd_q];

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: PC, RUN/HALT control,
// JUMP folding, redirect handling and the fetch queue.
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter int          MEM_DEPTH = 25,
    parameter int          QDEPTH    = 4,
    parameter logic [31:0] RESET_PC  = 32'd0
) (
    input  logic               clock,
    input  logic               reset_n,
    inst_fetch_unit_if.master  bus
);

    localparam int CW = $clog2(QDEPTH) + 1;

    fetch_state_e  state_q;
    logic [31:0]   pc_q, pc_d;
    logic          halted_q;
    logic [CW-1:0] count;
    fq_entry_t     head;
    fq_entry_t     push_data;
    logic          in_mem;
    logic          fetch_en;
    logic          jump;
    logic          push;
    logic          pop;

    assign in_mem   = pc_q < 32'(MEM_DEPTH);
    assign fetch_en = (state_q == ST_RUN) && in_mem
                   && (count < CW'(QDEPTH))
                   && !bus.redirect_valid;
    assign jump     = is_jump(bus.imem_data);
    assign push     = fetch_en && !jump;
    assign pop      = bus.out_valid && bus.out_ready
                   && !bus.redirect_valid;

    assign push_data.inst = bus.imem_data;
    assign push_data.pc   = pc_q;

    always_comb begin
        pc_d = pc_q;
        if (bus.redirect_valid) begin
            pc_d = bus.redirect_pc;
        end else if (fetch_en) begin
            pc_d = jump ? jump_target(bus.imem_data)
                        : pc_q + 32'd1;
        end
    end

    // Redirect always restarts in RUN; HALT is re-entered a cycle later if needed.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= ST_RUN;
            halted_q <= 1'b0;
            pc_q     <= RESET_PC;
        end else begin
            pc_q <= pc_d;
            unique case (1'b1)
                bus.redirect_valid: begin
                    state_q  <= ST_RUN;
                    halted_q <= 1'b0;
                end
                (state_q == ST_RUN) && !in_mem: begin
                    state_q  <= ST_HALT;
                    halted_q <= 1'b1;
                end
                default: begin
                    state_q  <= state_q;
                    halted_q <= halted_q;
                end
            endcase
        end
    end

    inst_fetch_unit_queue #(
        .QDEPTH(QDEPTH)
    ) u_queue (
        .clock       (clock),
        .reset_n     (reset_n),
        .flush_i     (bus.redirect_valid),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .count_o     (count),
        .head_o      (head)
    );

    assign bus.imem_addr = pc_q;
    assign bus.out_valid = (count != '0);
    assign bus.out_inst  = head.inst;
    assign bus.out_pc    = head.pc;
    assign bus.halted    = halted_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with a behavioural
// instruction memory of 32 words.
module tb_inst_fetch_unit;

    logic clock;
    logic reset_n;
    int   total;
    int   bad;

    logic [31:0] mem [32];

    inst_fetch_unit_if bus();

    inst_fetch_unit #(
        .MEM_DEPTH (25),
        .QDEPTH    (4),
        .RESET_PC  (32'd0)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    assign bus.imem_data = (bus.imem_addr < 32'd32)
                         ? mem[bus.imem_addr[4:0]] : 32'd0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic redirect(input logic [31:0] tgt);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = tgt;
        step();
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'd0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 32; i++) begin
            mem[i] = {6'b000001, 26'(i + 32'h100)};
        end
        mem[0] = 32'h0000_0000;
        mem[1] = {6'b000001, 26'h0000111};
        mem[2] = {6'b000010, 26'h0000222};
        mem[3] = {6'b000110, 26'h0000333};
        mem[4] = {6'b000101, 26'h0000444};
        mem[21] = {6'b010101, 26'd1};

        reset_n            = 1'b0;
        bus.out_ready      = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'd0;
        step();
        step();
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_inst", bus.out_inst, 32'd0);
        chk("rst_pc", bus.out_pc, 32'd0);
        chk("rst_halted", 32'(bus.halted), 32'd0);
        chk("rst_addr", bus.imem_addr, 32'd0);

        // 1: streaming with decode always ready
        reset_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t1_valid", 32'(bus.out_valid), 32'd1);
            chk("t1_pc", bus.out_pc, 32'(k));
            chk("t1_inst", bus.out_inst, mem[k]);
        end

        // 2: back-pressure from reset
        reset_n       = 1'b0;
        bus.out_ready = 1'b0;
        step();
        reset_n = 1'b1;
        for (int k = 0; k < 6; k++) step();
        chk("t2_addr_hold", bus.imem_addr, 32'd4);
        chk("t2_head", bus.out_pc, 32'd0);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("t2_valid", 32'(bus.out_valid), 32'd1);
            chk("t2_pc", bus.out_pc, 32'(k));
            step();
        end

        // 3: JUMP at 21 folds back to 1
        redirect(32'd20);
        chk("t3_empty", 32'(bus.out_valid), 32'd0);
        chk("t3_addr20", bus.imem_addr, 32'd20);
        step();
        chk("t3_pc20", bus.out_pc, 32'd20);
        chk("t3_addr21", bus.imem_addr, 32'd21);
        step();
        chk("t3_nojump_entry", 32'(bus.out_valid), 32'd0);
        chk("t3_addr1", bus.imem_addr, 32'd1);
        step();
        chk("t3_valid1", 32'(bus.out_valid), 32'd1);
        chk("t3_pc1", bus.out_pc, 32'd1);

        // 4: redirect flushes a queue of 5,6,7
        bus.out_ready = 1'b0;
        redirect(32'd5);
        step();
        step();
        step();
        chk("t4_head5", bus.out_pc, 32'd5);
        chk("t4_addr8", bus.imem_addr, 32'd8);
        bus.out_ready = 1'b1;
        redirect(32'd2);
        chk("t4_flushed", 32'(bus.out_valid), 32'd0);
        chk("t4_addr2", bus.imem_addr, 32'd2);
        step();
        chk("t4_valid2", 32'(bus.out_valid), 32'd1);
        chk("t4_pc2", bus.out_pc, 32'd2);

        // 5: run off the end of memory
        mem[21] = {6'b000001, 26'h0000555};
        redirect(32'd20);
        for (int k = 20; k < 25; k++) begin
            step();
            chk("t5_pc", bus.out_pc, 32'(k));
        end
        step();
        chk("t5_halted", 32'(bus.halted), 32'd1);
        chk("t5_drained", 32'(bus.out_valid), 32'd0);
        chk("t5_addr25", bus.imem_addr, 32'd25);
        step();
        step();
        chk("t5_addr_stable", bus.imem_addr, 32'd25);
        chk("t5_still_halted", 32'(bus.halted), 32'd1);
        redirect(32'd3);
        chk("t5_unhalt", 32'(bus.halted), 32'd0);
        chk("t5_addr3", bus.imem_addr, 32'd3);
        step();
        chk("t5_valid3", 32'(bus.out_valid), 32'd1);
        chk("t5_pc3", bus.out_pc, 32'd3);

        // redirect beyond memory re-halts a cycle later
        redirect(32'd30);
        chk("rb_not_yet", 32'(bus.halted), 32'd0);
        chk("rb_addr30", bus.imem_addr, 32'd30);
        step();
        chk("rb_halted", 32'(bus.halted), 32'd1);
        chk("rb_empty", 32'(bus.out_valid), 32'd0);

        // 6: reset with three entries queued
        bus.out_ready = 1'b0;
        redirect(32'd10);
        step();
        step();
        step();
        chk("t6_queued", bus.out_pc, 32'd10);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        chk("t6_valid", 32'(bus.out_valid), 32'd0);
        chk("t6_addr", bus.imem_addr, 32'd0);
        chk("t6_halted", 32'(bus.halted), 32'd0);
        chk("t6_pc", bus.out_pc, 32'd0);
        step();
        chk("t6_restart", 32'(bus.out_valid), 32'd1);
        chk("t6_restart_pc", bus.out_pc, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
